uart_tx_8n1: RTL and testbench

//   UART transmitter, 8N1, LSB first, idle-high line; transmit-side counterpart of the board's UART receiver.

---
 rtl/uart_pkg.sv | 8 +
 rtl/uart_byte_fifo.sv | 57 +++++
 rtl/uart_tx_8n1.sv | 119 +++++++++++
 tb/tb_uart_tx_8n1.sv | 342 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared UART definitions used by the transmitter and the receiver.
package uart_pkg;

  localparam int CLKS_PER_BIT_115K2 = 434;

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} uart_state_t;

endpackage

// File: rtl/uart_byte_fifo.sv
// Synchronous byte FIFO with a one-bit-wider level counter so full and empty stay distinct.
module uart_byte_fifo #(
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push_i,
  input  logic [7:0]               data_i,
  input  logic                     pop_i,
  output logic [7:0]               data_o,
  output logic                     full_o,
  output logic                     empty_o,
  output logic [$clog2(DEPTH):0]   level_o
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [7:0]       mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q;
  logic [PTR_W-1:0] rd_ptr_q;
  logic [PTR_W:0]   level_q;
  logic             do_push;
  logic             do_pop;

  assign full_o  = (level_q == (PTR_W + 1)'(DEPTH));
  assign empty_o = (level_q == '0);
  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;
  assign data_o  = mem_q[rd_ptr_q];
  assign level_o = level_q;

  // NOTE: the storage array has no reset; an entry is only read after it was written,
  // so clearing the pointers and level is enough and keeps the array as plain RAM.
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem_q[wr_ptr_q] <= data_i;
    end
  end

  // NOTE: sequential state is always updated with <= so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      case ({do_push, do_pop})
        2'b10:   level_q <= level_q + 1'b1;
        2'b01:   level_q <= level_q - 1'b1;
        default: level_q <= level_q;
      endcase
    end
  end

endmodule

// File: rtl/uart_tx_8n1.sv
// 8N1 UART transmitter: byte FIFO, cts_n synchroniser, bit-timer FSM and a registered txd.
module uart_tx_8n1
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = CLKS_PER_BIT_115K2,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [7:0]                    tx_data,
  input  logic                          tx_valid,
  output logic                          tx_ready,
  input  logic                          cts_n,
  output logic                          txd,
  output logic                          busy,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);

  localparam int TIMER_W = $clog2(CLKS_PER_BIT);
  localparam logic [TIMER_W-1:0] TICK_VAL = TIMER_W'(CLKS_PER_BIT - 1);

  logic [1:0]         cts_sync_q;
  logic               cts_s;
  uart_state_t        state_q;
  logic [TIMER_W-1:0] timer_q;
  logic [2:0]         idx_q;
  logic [7:0]         shift_q;
  logic               txd_q;
  logic               tick;
  logic               can_start;
  logic               pop;
  logic [7:0]         fifo_data;
  logic               fifo_full;
  logic               fifo_empty;

  uart_byte_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (tx_valid),
    .data_i  (tx_data),
    .pop_i   (pop),
    .data_o  (fifo_data),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .level_o (fifo_level)
  );

  // Resets to "not clear" so nothing is sent until the pin has been seen low twice.
  always_ff @(posedge clk) begin
    if (rst) cts_sync_q <= 2'b11;
    else     cts_sync_q <= {cts_sync_q[0], cts_n};
  end
  assign cts_s = cts_sync_q[1];

  assign tick      = (timer_q == TICK_VAL);
  assign can_start = !fifo_empty && !cts_s;
  // Flow control is only consulted at frame boundaries, so a frame is never cut short.
  assign pop       = can_start && ((state_q == IDLE) || ((state_q == STOP) && tick));

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      timer_q <= '0;
      idx_q   <= '0;
      shift_q <= '0;
      txd_q   <= 1'b1;
    end else begin
      timer_q <= tick ? '0 : timer_q + 1'b1;
      case (state_q)
        IDLE: begin
          timer_q <= '0;
          txd_q   <= 1'b1;
          if (pop) begin
            state_q <= START;
            shift_q <= fifo_data;
            txd_q   <= 1'b0;
          end
        end
        START: begin
          if (tick) begin
            state_q <= DATA;
            idx_q   <= '0;
            txd_q   <= shift_q[0];
          end
        end
        DATA: begin
          if (tick) begin
            shift_q <= {1'b0, shift_q[7:1]};
            if (idx_q == 3'd7) begin
              state_q <= STOP;
              txd_q   <= 1'b1;
            end else begin
              idx_q <= idx_q + 1'b1;
              txd_q <= shift_q[1];
            end
          end
        end
        STOP: begin
          if (tick) begin
            if (pop) begin
              state_q <= START;
              shift_q <= fifo_data;
              txd_q   <= 1'b0;
            end else begin
              state_q <= IDLE;
              txd_q   <= 1'b1;
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign txd      = txd_q;
  assign tx_ready = !fifo_full;
  assign busy     = (state_q != IDLE) || !fifo_empty;

endmodule

// File: tb/tb_uart_tx_8n1.sv
// Self-checking bench for uart_tx_8n1: a line decoder turns txd back into bytes for a scoreboard.
module tb_uart_tx_8n1;
  import uart_pkg::*;

  localparam int C  = 8;
  localparam int D  = 4;
  localparam int LW = $clog2(D) + 1;
  localparam int C2 = CLKS_PER_BIT_115K2;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [7:0]    tx_data = '0;
  logic          tx_valid = 1'b0;
  logic          tx_ready;
  logic          cts_n = 1'b1;
  logic          txd;
  logic          busy;
  logic [LW-1:0] fifo_level;

  logic [7:0]    tx_data2 = '0;
  logic          tx_valid2 = 1'b0;
  logic          tx_ready2;
  logic          cts_n2 = 1'b0;
  logic          txd2;
  logic          busy2;
  logic [2:0]    fifo_level2;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int frame_err = 0;
  logic [7:0] exp_q [$];
  logic [7:0] rx_q [$];
  int         start_q [$];

  uart_tx_8n1 #(.CLKS_PER_BIT(C), .FIFO_DEPTH(D)) dut (
    .clk(clk), .rst(rst), .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .cts_n(cts_n), .txd(txd), .busy(busy), .fifo_level(fifo_level)
  );

  uart_tx_8n1 dut_def (
    .clk(clk), .rst(rst), .tx_data(tx_data2), .tx_valid(tx_valid2), .tx_ready(tx_ready2),
    .cts_n(cts_n2), .txd(txd2), .busy(busy2), .fifo_level(fifo_level2)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Line-level receiver: samples each bit in its middle, like a far-end UART would.
  initial begin : decoder
    logic [7:0] b;
    forever begin
      @(negedge txd);
      #1;
      start_q.push_back(cyc);
      repeat (C / 2) step();
      if (txd !== 1'b0) frame_err++;
      for (int i = 0; i < 8; i++) begin
        repeat (C) step();
        b[i] = txd;
      end
      repeat (C) step();
      if (txd !== 1'b1) frame_err++;
      rx_q.push_back(b);
    end
  end

  task automatic push_byte(input logic [7:0] b);
    int k = 0;
    while (tx_ready !== 1'b1 && k < 2000) begin
      step();
      k++;
    end
    tx_data  = b;
    tx_valid = 1'b1;
    step();
    tx_valid = 1'b0;
    exp_q.push_back(b);
  endtask

  task automatic wait_rx(input int n, input int budget);
    int k = 0;
    while (rx_q.size() < n && k < budget) begin
      step();
      k++;
    end
  endtask

  task automatic wait_idle_flush();
    int k = 0;
    while (busy !== 1'b0 && k < 2000) begin
      step();
      k++;
    end
    repeat (C) step();
    rx_q.delete();
    exp_q.delete();
    start_q.delete();
    frame_err = 0;
  endtask

  task automatic test_reset();
    repeat (3) step();
    total++; if (txd !== 1'b1) begin bad++; $display("FAIL rst_txd_held: got %b want 1", txd); end
    rst = 1'b0;
    step();
    total++; if (txd !== 1'b1) begin bad++; $display("FAIL rst_txd: got %b want 1", txd); end
    total++; if (tx_ready !== 1'b1) begin bad++; $display("FAIL rst_ready: got %b want 1", tx_ready); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL rst_busy: got %b want 0", busy); end
    total++; if (fifo_level !== '0) begin bad++; $display("FAIL rst_level: got %0d want 0", fifo_level); end
    total++; if (txd2 !== 1'b1) begin bad++; $display("FAIL rst_txd_default: got %b want 1", txd2); end
  endtask

  task automatic test_basic_frame();
    logic [9:0] fr;
    fr = {1'b1, 8'hA5, 1'b0};
    cts_n = 1'b0;
    repeat (3) step();
    tx_data  = 8'hA5;
    tx_valid = 1'b1;
    step();
    tx_valid = 1'b0;
    total++; if (txd !== 1'b1) begin bad++; $display("FAIL a5_txd_before_start: got %b want 1", txd); end
    total++; if (busy !== 1'b1) begin bad++; $display("FAIL a5_busy_queued: got %b want 1", busy); end
    step();
    for (int i = 0; i < 10 * C; i++) begin
      total++;
      if (txd !== fr[i / C]) begin
        bad++; $display("FAIL a5_wave cycle %0d: got %b want %b", i, txd, fr[i / C]);
      end
      if (i == 10 * C - 1) begin
        total++; if (busy !== 1'b1) begin bad++; $display("FAIL a5_busy_in_stop: got %b want 1", busy); end
      end
      step();
    end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL a5_busy_after: got %b want 0", busy); end
    total++; if (txd !== 1'b1) begin bad++; $display("FAIL a5_txd_idle: got %b want 1", txd); end
    total++; if (rx_q.size() != 1) begin bad++; $display("FAIL a5_rx_count: got %0d want 1", rx_q.size()); end
    else if (rx_q[0] !== 8'hA5) begin bad++; $display("FAIL a5_rx_byte: got %h want a5", rx_q[0]); end
    total++; if (frame_err != 0) begin bad++; $display("FAIL a5_framing: got %0d want 0", frame_err); end
  endtask

  task automatic test_back_to_back();
    logic [7:0] bytes [3];
    int k;
    int drop;
    bytes = '{8'h00, 8'hFF, 8'h55};
    wait_idle_flush();
    for (int i = 0; i < 3; i++) begin
      tx_data  = bytes[i];
      tx_valid = 1'b1;
      step();
      exp_q.push_back(bytes[i]);
    end
    tx_valid = 1'b0;
    k = 0;
    while (busy !== 1'b0 && k < 400) begin
      step();
      k++;
    end
    drop = cyc;
    total++;
    if (start_q.size() != 3) begin
      bad++; $display("FAIL b2b_frames: got %0d want 3", start_q.size());
    end else begin
      total++; if (start_q[1] - start_q[0] != 10 * C) begin bad++; $display("FAIL b2b_gap1: got %0d want %0d", start_q[1] - start_q[0], 10 * C); end
      total++; if (start_q[2] - start_q[1] != 10 * C) begin bad++; $display("FAIL b2b_gap2: got %0d want %0d", start_q[2] - start_q[1], 10 * C); end
      total++; if (drop - start_q[0] != 30 * C) begin bad++; $display("FAIL b2b_total: got %0d want %0d", drop - start_q[0], 30 * C); end
    end
    wait_rx(3, 100);
    for (int i = 0; i < 3; i++) begin
      total++;
      if (i >= rx_q.size() || rx_q[i] !== exp_q[i]) begin
        bad++; $display("FAIL b2b_byte%0d: got %h want %h", i, (i < rx_q.size()) ? rx_q[i] : 8'hxx, exp_q[i]);
      end
    end
  endtask

  task automatic test_flow_control();
    logic [7:0] b;
    int lvl;
    bit line_low;
    wait_idle_flush();
    cts_n = 1'b1;
    repeat (3) step();
    lvl = 0;
    for (int i = 0; i < 5; i++) begin
      b = 8'($urandom);
      tx_data  = b;
      tx_valid = 1'b1;
      step();
      if (lvl < D) begin
        exp_q.push_back(b);
        lvl++;
      end
    end
    tx_valid = 1'b0;
    total++; if (fifo_level !== LW'(lvl)) begin bad++; $display("FAIL fc_level: got %0d want %0d", fifo_level, lvl); end
    total++; if (tx_ready !== 1'b0) begin bad++; $display("FAIL fc_ready: got %b want 0", tx_ready); end
    total++; if (busy !== 1'b1) begin bad++; $display("FAIL fc_busy: got %b want 1", busy); end
    line_low = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (txd !== 1'b1) line_low = 1'b1;
      step();
    end
    total++; if (line_low) begin bad++; $display("FAIL fc_line_held: got low want high"); end
    cts_n = 1'b0;
    wait_rx(D, D * 10 * C + 50);
    repeat (3 * C) step();
    total++; if (rx_q.size() != D) begin bad++; $display("FAIL fc_rx_count: got %0d want %0d", rx_q.size(), D); end
    for (int i = 0; i < D; i++) begin
      total++;
      if (i >= rx_q.size() || rx_q[i] !== exp_q[i]) begin
        bad++; $display("FAIL fc_byte%0d: got %h want %h", i, (i < rx_q.size()) ? rx_q[i] : 8'hxx, exp_q[i]);
      end
    end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL fc_busy_end: got %b want 0", busy); end
  endtask

  task automatic test_cts_midframe();
    int k;
    int t0;
    wait_idle_flush();
    cts_n = 1'b0;
    repeat (3) step();
    push_byte(8'($urandom));
    push_byte(8'($urandom));
    k = 0;
    while (start_q.size() < 1 && k < 20) begin step(); k++; end
    t0 = (start_q.size() > 0) ? start_q[0] : cyc;
    while (cyc < t0 + 4 * C + 3) step();
    cts_n = 1'b1;
    while (cyc < t0 + 14 * C) step();
    total++; if (rx_q.size() != 1) begin bad++; $display("FAIL cts_first_frame: got %0d frames want 1", rx_q.size()); end
    else if (rx_q[0] !== exp_q[0]) begin bad++; $display("FAIL cts_first_byte: got %h want %h", rx_q[0], exp_q[0]); end
    total++; if (frame_err != 0) begin bad++; $display("FAIL cts_framing: got %0d want 0", frame_err); end
    total++; if (fifo_level !== LW'(1)) begin bad++; $display("FAIL cts_level_held: got %0d want 1", fifo_level); end
    total++; if (txd !== 1'b1) begin bad++; $display("FAIL cts_line_idle: got %b want 1", txd); end
    cts_n = 1'b0;
    wait_rx(2, 200);
    total++; if (rx_q.size() != 2) begin bad++; $display("FAIL cts_second_frame: got %0d frames want 2", rx_q.size()); end
    else begin
      total++; if (rx_q[1] !== exp_q[1]) begin bad++; $display("FAIL cts_second_byte: got %h want %h", rx_q[1], exp_q[1]); end
      total++; if (start_q[1] <= t0 + 14 * C) begin bad++; $display("FAIL cts_resume_time: got %0d want > %0d", start_q[1], t0 + 14 * C); end
    end
  endtask

  task automatic test_random_stream();
    wait_idle_flush();
    cts_n = 1'b0;
    for (int i = 0; i < 8; i++) begin
      push_byte(8'($urandom));
      repeat ($urandom_range(0, 3)) step();
    end
    wait_rx(8, 8 * 10 * C + 200);
    total++; if (rx_q.size() != 8) begin bad++; $display("FAIL rnd_count: got %0d want 8", rx_q.size()); end
    for (int i = 0; i < 8; i++) begin
      total++;
      if (i >= rx_q.size() || rx_q[i] !== exp_q[i]) begin
        bad++; $display("FAIL rnd_byte%0d: got %h want %h", i, (i < rx_q.size()) ? rx_q[i] : 8'hxx, exp_q[i]);
      end
    end
    total++; if (frame_err != 0) begin bad++; $display("FAIL rnd_framing: got %0d want 0", frame_err); end
  endtask

  task automatic test_reset_midframe();
    int k;
    int t0;
    logic [7:0] b;
    wait_idle_flush();
    cts_n = 1'b0;
    push_byte(8'($urandom));
    push_byte(8'($urandom));
    k = 0;
    while (start_q.size() < 1 && k < 20) begin step(); k++; end
    t0 = (start_q.size() > 0) ? start_q[0] : cyc;
    while (cyc < t0 + 6 * C + 3) step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    total++; if (txd !== 1'b1) begin bad++; $display("FAIL rmf_txd: got %b want 1", txd); end
    total++; if (fifo_level !== '0) begin bad++; $display("FAIL rmf_level: got %0d want 0", fifo_level); end
    total++; if (tx_ready !== 1'b1) begin bad++; $display("FAIL rmf_ready: got %b want 1", tx_ready); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL rmf_busy: got %b want 0", busy); end
    repeat (10 * C) step();
    rx_q.delete();
    exp_q.delete();
    start_q.delete();
    frame_err = 0;
    b = 8'($urandom);
    push_byte(b);
    wait_rx(1, 200);
    total++; if (rx_q.size() != 1) begin bad++; $display("FAIL rmf_rx_count: got %0d want 1", rx_q.size()); end
    else if (rx_q[0] !== b) begin bad++; $display("FAIL rmf_rx_byte: got %h want %h", rx_q[0], b); end
    total++; if (frame_err != 0) begin bad++; $display("FAIL rmf_framing: got %0d want 0", frame_err); end
  endtask

  task automatic test_default_baud();
    int k;
    int low_len;
    logic [7:0] b;
    logic stop_bit;
    tx_data2  = 8'h41;
    tx_valid2 = 1'b1;
    step();
    tx_valid2 = 1'b0;
    k = 0;
    while (txd2 === 1'b1 && k < 20) begin step(); k++; end
    low_len = 0;
    while (txd2 === 1'b0 && low_len < 1000) begin step(); low_len++; end
    total++; if (low_len != C2) begin bad++; $display("FAIL def_start_len: got %0d want %0d", low_len, C2); end
    repeat (C2 / 2) step();
    b[0] = txd2;
    for (int i = 1; i < 8; i++) begin
      repeat (C2) step();
      b[i] = txd2;
    end
    repeat (C2) step();
    stop_bit = txd2;
    total++; if (b !== 8'h41) begin bad++; $display("FAIL def_byte: got %h want 41", b); end
    total++; if (stop_bit !== 1'b1) begin bad++; $display("FAIL def_stop: got %b want 1", stop_bit); end
  endtask

  initial begin
    test_reset();
    test_basic_frame();
    test_back_to_back();
    test_flow_control();
    test_cts_midframe();
    test_random_stream();
    test_reset_midframe();
    test_default_baud();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
